// File: rtl/panel_sequencer.sv
// -----------------------------------------------------------------------------
// panel_sequencer
//
// Front-panel controller for a small processor. Raw switch inputs pass through
// synchronisers and debouncers and become single-cycle press events. A state
// machine uses these events to control the processor (run, halt, single step,
// reset pulse) and to run front-panel memory/IO bus cycles (deposit/examine).
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   sw_sr        switch register (address / deposit data source)
//   sw_lock      panel lock switch (1 = locked, all presses ignored)
//   sw_*         raw active-low momentary switches
//   iend         active-low instruction-end strobe from the microcode
//   fp_ack       front-panel bus acknowledge
//   fp_rdata     front-panel bus read data
//   clken        processor clock enable
//   step         single-step mode
//   halt/isstop  processor stopped
//   isrun        processor running (including while it is halting)
//   sys_reset    active-low system reset pulse
//   fp_req       front-panel bus request
//   fp_we        bus write strobe (deposit)
//   fp_io        bus I/O-space select
//   fp_addr      panel address register
//   fp_wdata     deposit data, captured when the deposit is pressed
//   fp_data      data latched by the last examine
//   fp_err       sticky bus-timeout flag
// -----------------------------------------------------------------------------
module panel_sequencer #(
    parameter int W       = 16,
    parameter int DEB     = 4,
    parameter int RSTLEN  = 8,
    parameter int TMO     = 255,
    parameter int AUTOINC = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] sw_sr,
    input  logic         sw_lock,
    input  logic         sw_reset_in,
    input  logic         sw_start,
    input  logic         sw_stop,
    input  logic         sw_cont,
    input  logic         sw_step,
    input  logic         sw_dep_mem,
    input  logic         sw_dep_io,
    input  logic         sw_exam_mem,
    input  logic         sw_exam_io,
    input  logic         sw_ld_addr,
    input  logic         sw_inc_addr,
    input  logic         iend,
    input  logic         fp_ack,
    input  logic [W-1:0] fp_rdata,
    output logic         clken,
    output logic         step,
    output logic         halt,
    output logic         isrun,
    output logic         isstop,
    output logic         sys_reset,
    output logic         fp_req,
    output logic         fp_we,
    output logic         fp_io,
    output logic [W-1:0] fp_addr,
    output logic [W-1:0] fp_wdata,
    output logic [W-1:0] fp_data,
    output logic         fp_err
);

    localparam int NSW = 12;
    localparam int CW  = (DEB > 2)    ? $clog2(DEB)    : 1;
    localparam int RCW = (RSTLEN > 2) ? $clog2(RSTLEN) : 1;
    localparam int TCW = (TMO > 2)    ? $clog2(TMO)    : 1;

    // Switch vector index doubles as event priority: a lower index wins.
    // Index 0 is the lock switch, which is a level and never an event.
    localparam int I_RST   = 1;
    localparam int I_STOP  = 2;
    localparam int I_START = 3;
    localparam int I_CONT  = 4;
    localparam int I_STEP  = 5;
    localparam int I_DEPM  = 6;
    localparam int I_DEPIO = 7;
    localparam int I_EXM   = 8;
    localparam int I_EXIO  = 9;
    localparam int I_LD    = 10;
    localparam int I_INC   = 11;

    typedef enum logic [2:0] {
        ST_STOP,
        ST_RSTP,
        ST_RUN,
        ST_HALTING,
        ST_STEPPING,
        ST_MEMCYC
    } state_t;

    logic [NSW-1:0]         rawSw;
    logic [NSW-1:0]         sync1_q;
    logic [NSW-1:0]         sync2_q;
    logic [NSW-1:0]         level_q;
    logic [NSW-1:1]         levelPrev_q;
    logic [NSW-1:0][CW-1:0] cnt_q;
    logic [NSW-1:1]         press;
    logic [NSW-1:1]         win;

    state_t         state_q, state_d;
    logic           goRun_q, goRun_d;
    logic [RCW-1:0] rstCnt_q, rstCnt_d;
    logic [TCW-1:0] tmoCnt_q, tmoCnt_d;
    logic [W-1:0]   addr_q, addr_d;
    logic [W-1:0]   data_q, data_d;
    logic [W-1:0]   wdata_q, wdata_d;
    logic           we_q, we_d;
    logic           io_q, io_d;
    logic           err_q, err_d;
    logic           accept;

    assign rawSw = {sw_inc_addr, sw_ld_addr, sw_exam_io, sw_exam_mem, sw_dep_io,
                    sw_dep_mem, sw_step, sw_cont, sw_start, sw_stop,
                    sw_reset_in, sw_lock};

    // Synchroniser plus debouncer for every switch. The counter tracks how
    // many consecutive samples disagree with the debounced level; any
    // agreeing sample restarts it, so short glitches never reach the level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            level_q     <= '1;
            levelPrev_q <= '1;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= rawSw;
            sync2_q     <= sync1_q;
            levelPrev_q <= level_q[NSW-1:1];
            for (int i = 0; i < NSW; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(DEB - 1)) begin
                    level_q[i] <= sync2_q[i];
                    cnt_q[i]   <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // A press is the debounced 1->0 edge, so holding a switch gives one pulse.
    assign press = levelPrev_q & ~level_q[NSW-1:1];

    // Keep only the highest-priority press, and nothing while locked.
    always_comb begin
        win = '0;
        if (!level_q[0]) begin
            for (int i = 1; i < NSW; i++) begin
                if (press[i] && (win == '0)) begin
                    win[i] = 1'b1;
                end
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_STOP;
            goRun_q  <= 1'b0;
            rstCnt_q <= '0;
            tmoCnt_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            io_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            goRun_q  <= goRun_d;
            rstCnt_q <= rstCnt_d;
            tmoCnt_q <= tmoCnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            io_q     <= io_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic. goRun_q remembers whether the reset pulse came from
    // start (continue into RUN) or from reset_in (fall back to STOP).
    always_comb begin
        state_d  = state_q;
        goRun_d  = goRun_q;
        rstCnt_d = rstCnt_q;
        tmoCnt_d = tmoCnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        io_d     = io_q;
        err_d    = err_q;
        accept   = 1'b0;

        if (win[I_RST]) begin
            state_d  = ST_RSTP;
            goRun_d  = 1'b0;
            rstCnt_d = '0;
            accept   = 1'b1;
        end else begin
            case (state_q)
                ST_STOP: begin
                    if (win[I_START]) begin
                        state_d  = ST_RSTP;
                        goRun_d  = 1'b1;
                        rstCnt_d = '0;
                        accept   = 1'b1;
                    end else if (win[I_CONT]) begin
                        state_d = ST_RUN;
                        accept  = 1'b1;
                    end else if (win[I_STEP]) begin
                        state_d = ST_STEPPING;
                        accept  = 1'b1;
                    end else if (|win[I_EXIO:I_DEPM]) begin
                        state_d  = ST_MEMCYC;
                        we_d     = win[I_DEPM] | win[I_DEPIO];
                        io_d     = win[I_DEPIO] | win[I_EXIO];
                        wdata_d  = sw_sr;
                        tmoCnt_d = '0;
                        accept   = 1'b1;
                    end else if (win[I_LD]) begin
                        addr_d = sw_sr;
                        accept = 1'b1;
                    end else if (win[I_INC]) begin
                        addr_d = addr_q + 1'b1;
                        accept = 1'b1;
                    end
                end
                ST_RSTP: begin
                    if (rstCnt_q == RCW'(RSTLEN - 1)) begin
                        state_d = goRun_q ? ST_RUN : ST_STOP;
                    end else begin
                        rstCnt_d = rstCnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (win[I_STOP]) begin
                        state_d = ST_HALTING;
                        accept  = 1'b1;
                    end
                end
                ST_HALTING: begin
                    if (!iend) begin
                        state_d = ST_STOP;
                    end
                end
                ST_STEPPING: begin
                    if (!iend) begin
                        state_d = ST_STOP;
                    end else if (win[I_STOP]) begin
                        state_d = ST_HALTING;
                        accept  = 1'b1;
                    end
                end
                ST_MEMCYC: begin
                    // An acknowledge on the final wait cycle still completes.
                    if (fp_ack) begin
                        if (!we_q) begin
                            data_d = fp_rdata;
                        end
                        if (AUTOINC != 0) begin
                            addr_d = addr_q + 1'b1;
                        end
                        state_d = ST_STOP;
                    end else if (tmoCnt_q == TCW'(TMO - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        tmoCnt_d = tmoCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_STOP;
                end
            endcase
        end

        if (accept) begin
            err_d = 1'b0;
        end
    end

    assign clken     = (state_q == ST_RUN) || (state_q == ST_HALTING) || (state_q == ST_STEPPING);
    assign step      = (state_q == ST_STEPPING);
    assign halt      = (state_q == ST_STOP);
    assign isstop    = (state_q == ST_STOP);
    assign isrun     = (state_q == ST_RUN) || (state_q == ST_HALTING);
    assign sys_reset = (state_q != ST_RSTP);
    assign fp_req    = (state_q == ST_MEMCYC);
    assign fp_we     = we_q;
    assign fp_io     = io_q;
    assign fp_addr   = addr_q;
    assign fp_wdata  = wdata_q;
    assign fp_data   = data_q;
    assign fp_err    = err_q;

endmodule

// File: doc/panel_sequencer.md
PANEL_SEQUENCER -- requirements
Module: panel_sequencer

Interface
REQ-001 The block SHALL take parameter W, default 16, as the width of the switch register, address and data.
REQ-002 The block SHALL take parameter DEB, default 4, as the number of consecutive stable samples a switch needs to change its debounced level.
REQ-003 The block SHALL take parameter RSTLEN, default 8, as the length in clk cycles of the sys_reset pulse.
REQ-004 The block SHALL take parameter TMO, default 255, as the number of cycles to wait for fp_ack.
REQ-005 The block SHALL take parameter AUTOINC, default 1, which when 1 increments the address after each deposit or examine.
REQ-006 Port clk SHALL be an input, 1 bit wide, and is the single system clock.
REQ-007 Port reset SHALL be an input, 1 bit wide, and is the asynchronous, active-low reset.
REQ-008 Port sw_sr SHALL be an input, W bits wide, carrying the switch register (data and address source).
REQ-009 Port sw_lock SHALL be an input, 1 bit wide; 1 means the panel is locked and 0 means unlocked.
REQ-010 Ports sw_reset_in, sw_start, sw_stop, sw_cont and sw_step SHALL each be a 1-bit input carrying a raw, active-low momentary switch.
REQ-011 Ports sw_dep_mem, sw_dep_io, sw_exam_mem, sw_exam_io, sw_ld_addr and sw_inc_addr SHALL each be a 1-bit input carrying a raw, active-low momentary switch.
REQ-012 Port iend SHALL be an input, 1 bit wide, carrying the active-low instruction-end signal from the microcode.
REQ-013 Ports fp_ack (1 bit) and fp_rdata (W bits) SHALL be inputs carrying the bus-cycle acknowledge and the read data.
REQ-014 Ports clken, step, halt, isrun and isstop SHALL each be a 1-bit output, active-high, carrying clock enable, step mode and status.
REQ-015 Port sys_reset SHALL be an output, 1 bit wide, carrying an active-low system reset pulse.
REQ-016 Ports fp_req, fp_we and fp_io SHALL each be a 1-bit output carrying the front-panel bus request, write strobe and I/O-space select.
REQ-017 Ports fp_addr, fp_wdata and fp_data SHALL each be a W-bit output carrying the address register, deposit data and latched examine data.
REQ-018 Port fp_err SHALL be an output, 1 bit wide, carrying a sticky bus-timeout flag.

Function
REQ-019 Each switch SHALL pass through a 2-flop synchroniser, then a debouncer whose level changes only after DEB identical consecutive samples.
REQ-020 A press event SHALL be a single-cycle pulse generated on the debounced 1->0 transition; holding a switch SHALL produce no further events.
REQ-021 While the debounced sw_lock is 1, every press event SHALL be discarded.
REQ-022 Events arriving in the same cycle SHALL be resolved with priority reset_in > stop > start > cont > step > dep/exam > ld_addr > inc_addr; the lower-priority events SHALL be dropped.
REQ-023 The FSM SHALL have states STOP, RSTP, RUN, HALTING, STEPPING and MEMCYC.
REQ-024 In STOP, a start event SHALL go to RSTP and then to RUN.
REQ-025 In STOP, a cont event SHALL go to RUN, a step event to STEPPING, and a dep or exam event to MEMCYC.
REQ-026 In STOP, ld_addr SHALL load fp_addr from sw_sr, and inc_addr SHALL set fp_addr to fp_addr+1 modulo 2^W.
REQ-027 In RSTP, sys_reset SHALL be 0 for exactly RSTLEN cycles.
REQ-028 A reset_in event in any state SHALL go to RSTP, drop fp_req, and return to STOP afterwards.
REQ-029 In RUN, a stop event SHALL go to HALTING.
REQ-030 In HALTING and STEPPING, clken SHALL stay 1 until iend=0 is sampled, and the state SHALL become STOP on that same edge.
REQ-031 A stop event in STEPPING SHALL go to HALTING; all other events in RUN, HALTING, STEPPING and MEMCYC SHALL be ignored.
REQ-032 Outputs SHALL be decoded from the registered state as follows: clken=1 in RUN, HALTING and STEPPING; step=1 in STEPPING; halt=isstop=1 in STOP; isrun=1 in RUN and HALTING.
REQ-033 In MEMCYC, fp_req=1 SHALL be held with fp_addr, fp_we (1 for dep), fp_io (1 for the io variants) and fp_wdata=sw_sr (captured at the event) all stable until fp_ack=1 is sampled.
REQ-034 On fp_ack in MEMCYC, an examine SHALL latch fp_rdata into fp_data, fp_addr SHALL increment if AUTOINC=1, the state SHALL become STOP, and fp_req SHALL be 0 on the next cycle.
REQ-035 If fp_ack is absent for TMO cycles in MEMCYC, the cycle SHALL be aborted, fp_err SHALL be set to 1, the address SHALL not change, and the state SHALL become STOP.
REQ-036 fp_err SHALL clear on the next accepted event.
REQ-037 Incrementing fp_addr from all-ones SHALL wrap to 0.

Reset
REQ-038 reset=0 SHALL immediately force STOP and set the debouncers to the released (1) level.
REQ-039 reset=0 SHALL immediately set clken=0, step=0, halt=1, isstop=1, isrun=0, sys_reset=1, fp_req=0 and fp_err=0.
REQ-040 reset=0 SHALL immediately set fp_addr, fp_data, fp_we and fp_io to 0.
REQ-041 Reset asserted in the middle of any operation SHALL abandon it without completing.

Verification
REQ-042 Bench: sw_lock=1, press start -> no state change; sw_lock=0, press start -> sys_reset=0 for 8 cycles, then clken=1 and isrun=1.
REQ-043 Bench: in RUN press stop with iend=1 -> clken stays 1; iend=0 for one cycle -> STOP on that edge, clken=0 next cycle.
REQ-044 Bench: in STOP, sw_sr=16'hFFFF with ld_addr, then dep_mem, ack after 3 cycles -> fp_req held 3 cycles, fp_we=1, fp_addr=16'hFFFF, then fp_addr=16'h0000.
REQ-045 Bench: exam_io with no ack -> fp_err=1 after 255 cycles, fp_addr unchanged; next event -> fp_err=0.
REQ-046 Bench: switch bounce of 1-cycle glitches, then stop and step pressed in the same cycle -> exactly one event, stop wins.
REQ-047 Bench: reset asserted mid-MEMCYC -> fp_req=0 at once; after release, state STOP.
